// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a word-write data memory.
// Sub-word stores become a read-modify-write; loads are extended and returned registered.
module lsu_ctrl #(
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wr_data,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [31:0]     mem_rd_data,
  output logic            resp_valid,
  output logic [31:0]     resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [31:0]     merge_q, merge_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [RD_W-1:0] resp_rd_q, resp_rd_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     load_ext;

  always_comb begin
    load_ext = mem_rd_data;
    case (funct3_q)
      3'd0:    load_ext = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
      3'd1:    load_ext = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
      3'd4:    load_ext = {24'd0, mem_rd_data[7:0]};
      3'd5:    load_ext = {16'd0, mem_rd_data[15:0]};
      default: load_ext = mem_rd_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          rd_d     = req_rd;
          if (req_load && !req_store &&
              (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            state_d = S_LOAD;
          else if (req_store && !req_load && req_funct3 == 3'd2)
            state_d = S_STORE;
          else if (req_store && !req_load && (req_funct3 inside {3'd0, 3'd1}))
            state_d = S_RMW_RD;
          else
            state_d = S_ERR;
        end
      end
      S_LOAD: begin
        resp_valid_d = 1'b1;
        resp_data_d  = load_ext;
        resp_rd_d    = rd_q;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      S_STORE, S_RMW_WR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = 32'd0;
        resp_rd_d    = rd_q;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        // Keep the bytes just read above the stored byte/half so the word write is neutral there.
        merge_d = funct3_q[0] ? {mem_rd_data[31:16], wdata_q[15:0]}
                              : {mem_rd_data[31:8], wdata_q[7:0]};
        state_d = S_RMW_WR;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = 32'd0;
        resp_rd_d    = rd_q;
        resp_err_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      rd_q         <= '0;
      merge_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory strobes decode straight from state, so reset kills a pending write immediately.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    mem_addr    = (state_q == S_IDLE) ? 32'd0 : addr_q;
    mem_read    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write   = (state_q == S_STORE) || (state_q == S_RMW_WR);
    mem_wr_data = 32'd0;
    if (state_q == S_STORE)  mem_wr_data = wdata_q;
    if (state_q == S_RMW_WR) mem_wr_data = merge_q;
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory environment, directed vector table,
// reset-abort sequence and random requests checked against a byte-level model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_read, mem_write;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rd_data(mem_rd_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  // Environment memory: 256 bytes, addresses wrap, whole-word writes at mem_addr.
  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic        mem_clr, pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  assign ma = mem_addr[7:0];
  assign mem_rd_data = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (mem_write) begin
      mem[ma]        <= mem_wr_data[7:0];
      mem[ma + 8'd1] <= mem_wr_data[15:8];
      mem[ma + 8'd2] <= mem_wr_data[23:16];
      mem[ma + 8'd3] <= mem_wr_data[31:24];
    end else if (pre_we) begin
      mem[pre_a]        <= pre_d[7:0];
      mem[pre_a + 8'd1] <= pre_d[15:8];
      mem[pre_a + 8'd2] <= pre_d[23:16];
      mem[pre_a + 8'd3] <= pre_d[31:24];
    end
  end

  // Reference byte memory, updated per request from the ISA's byte semantics.
  logic [7:0] ref_mem [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a, input int k);
    logic [7:0] idx;
    idx = a[7:0] + 8'(k);
    return ref_mem[idx];
  endfunction

  task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] e_data, output logic [31:0] e_wr,
                       output logic e_err, output int e_lat, output int e_nrd,
                       output int e_nwr);
    logic [7:0] b0, b1, idx;
    int n;
    e_data = 32'd0; e_wr = 32'd0; e_err = 1'b0;
    e_lat = 1; e_nrd = 0; e_nwr = 0;
    if (ld && !st && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      b0 = rb(a, 0); b1 = rb(a, 1);
      e_nrd = 1;
      case (f3)
        3'd0: e_data = {{24{b0[7]}}, b0};
        3'd1: e_data = {{16{b1[7]}}, b1, b0};
        3'd4: e_data = {24'd0, b0};
        3'd5: e_data = {16'd0, b1, b0};
        default: e_data = {rb(a, 3), rb(a, 2), b1, b0};
      endcase
    end else if (st && !ld && (f3 inside {3'd0, 3'd1, 3'd2})) begin
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
        idx = a[7:0] + 8'(k);
        ref_mem[idx] = wd[8*k +: 8];
      end
      e_wr  = {rb(a, 3), rb(a, 2), rb(a, 1), rb(a, 0)};
      e_nwr = 1;
      e_nrd = (n == 4) ? 0 : 1;
      e_lat = (n == 4) ? 1 : 2;
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = w;
    @(posedge clk); #1;
    pre_we = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[8'(a + 8'(k))] = w[8*k +: 8];
  endtask

  // Drives one request, then watches the memory port and the response for a bounded number of cycles.
  task automatic run_req(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] e_data, input logic [31:0] e_wr, input logic e_err,
                         input int e_lat, input int e_nrd, input int e_nwr);
    int lat, nrd, nwr, stray;
    logic [31:0] wr, g_data;
    logic g_err;
    logic [4:0] g_rd;
    lat = 0; nrd = 0; nwr = 0; stray = 0; wr = 32'd0;
    g_data = 32'd0; g_err = 1'b0; g_rd = 5'd0;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    check({nm, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage while busy must be ignored.
    req_valid = 1'($urandom); req_load = 1'($urandom); req_store = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    check({nm, ".pulse_end"}, 32'(resp_valid), 32'd0);
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (mem_addr !== a) stray++;
      end
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wr = mem_wr_data;
      end else if (mem_wr_data !== 32'd0) stray++;
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i; g_data = resp_data; g_err = resp_err; g_rd = resp_rd;
      end
    end
    req_valid = 1'b0;
    check({nm, ".latency"}, 32'(lat), 32'(e_lat));
    check({nm, ".data"}, g_data, e_data);
    check({nm, ".err"}, 32'(g_err), 32'(e_err));
    check({nm, ".rd"}, 32'(g_rd), 32'(rd));
    check({nm, ".reads"}, 32'(nrd), 32'(e_nrd));
    check({nm, ".writes"}, 32'(nwr), 32'(e_nwr));
    check({nm, ".wr_data"}, wr, e_wr);
    check({nm, ".port_misuse"}, 32'(stray), 32'd0);
    check({nm, ".ready_at_resp"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic [4:0]  rd;
    logic [31:0] e_data, e_wr;
    logic        e_err;
    int          e_lat, e_nrd, e_nwr;
  } vec_t;

  function automatic vec_t mk(string nm, logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [4:0] rd, logic [31:0] e_data,
                              logic [31:0] e_wr, logic e_err, int e_lat, int e_nrd, int e_nwr);
    vec_t v;
    v.nm = nm; v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd;
    v.e_data = e_data; v.e_wr = e_wr; v.e_err = e_err;
    v.e_lat = e_lat; v.e_nrd = e_nrd; v.e_nwr = e_nwr;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [31:0] m_data, m_wr;
    logic m_err;
    int m_lat, m_nrd, m_nwr, viol;
    logic ld, st;
    logic [2:0] f3;
    int r;

    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_clr = 1'b1; pre_we = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_rd_err", {resp_rd, resp_err}, 32'd0);
    check("rst.mem_strobes", {mem_read, mem_write}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wr_data", mem_wr_data, 32'd0);

    preload(8'h10, 32'h8899AABB);
    preload(8'h14, 32'h44332211);

    tbl.push_back(mk("lb",      1, 0, 3'd0, 32'h13, 32'h0,        5'd1, 32'hFFFFFF88, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("lbu",     1, 0, 3'd4, 32'h13, 32'h0,        5'd2, 32'h00000088, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("lh",      1, 0, 3'd1, 32'h10, 32'h0,        5'd3, 32'hFFFFAABB, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("lw",      1, 0, 3'd2, 32'h10, 32'h0,        5'd4, 32'h8899AABB, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("lhu",     1, 0, 3'd5, 32'h12, 32'h0,        5'd5, 32'h00008899, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("sb",      0, 1, 3'd0, 32'h11, 32'h123456CC, 5'd7, 32'h0,        32'h118899CC, 0, 2, 1, 1));
    tbl.push_back(mk("lw_sb",   1, 0, 3'd2, 32'h10, 32'h0,        5'd8, 32'h8899CCBB, 32'h0,        0, 1, 1, 0));
    tbl.push_back(mk("sw",      0, 1, 3'd2, 32'h20, 32'hDEADBEEF, 5'd9, 32'h0,        32'hDEADBEEF, 0, 1, 0, 1));
    tbl.push_back(mk("lh_sw",   1, 0, 3'd1, 32'h22, 32'h0,        5'd10, 32'hFFFFDEAD, 32'h0,       0, 1, 1, 0));
    tbl.push_back(mk("err_ld3", 1, 0, 3'd3, 32'h10, 32'h0,        5'd11, 32'h0,       32'h0,        1, 1, 0, 0));
    tbl.push_back(mk("err_st5", 0, 1, 3'd5, 32'h10, 32'hFFFFFFFF, 5'd12, 32'h0,       32'h0,        1, 1, 0, 0));
    tbl.push_back(mk("err_both",1, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 5'd13, 32'h0,       32'h0,        1, 1, 0, 0));
    tbl.push_back(mk("err_none",0, 0, 3'd2, 32'h10, 32'h0,        5'd14, 32'h0,       32'h0,        1, 1, 0, 0));
    tbl.push_back(mk("sh",      0, 1, 3'd1, 32'h16, 32'h0000BEEF, 5'd15, 32'h0,       32'h0000BEEF, 0, 2, 1, 1));

    foreach (tbl[i]) begin
      // Keep the reference memory in step; expectations come from the table.
      model(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, m_data, m_wr, m_err, m_lat, m_nrd, m_nwr);
      run_req(tbl[i].nm, tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
              tbl[i].e_data, tbl[i].e_wr, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_nrd, tbl[i].e_nwr);
    end

    // Reset in the read half of an SH must suppress the write and the response.
    preload(8'h30, 32'h76543210);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h30; req_wdata = 32'h0000ABCD; req_rd = 5'd21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort.in_read", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.write_async", 32'(mem_write), 32'd0);
    viol = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_write || resp_valid) viol++;
    end
    rst = 1'b0;
    #1;
    check("abort.ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (mem_write || resp_valid || mem_read) viol++;
    end
    check("abort.no_activity", 32'(viol), 32'd0);
    check("abort.mem_kept", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h76543210);

    // Random traffic against the byte-level model.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      ld = (r >= 2 && r < 10) || r == 0;
      st = (r >= 10) || r == 0;
      f3 = (r % 5 == 0) ? 3'($urandom_range(0, 7)) :
           (ld ? 3'($urandom_range(0, 2)) + ($urandom_range(0, 1) ? 3'd0 : 3'd0) : 3'($urandom_range(0, 2)));
      if (ld && !st && $urandom_range(0, 2) == 0) f3 = $urandom_range(0, 1) ? 3'd4 : 3'd5;
      req_addr = $urandom_range(0, 255);
      model(ld, st, f3, req_addr, $urandom, m_data, m_wr, m_err, m_lat, m_nrd, m_nwr);
      // model consumed a fresh random word; replay the same data into the DUT via ref bytes
      run_req("rnd", ld, st, f3, req_addr, m_wr_src(ld, st, f3, req_addr), 5'($urandom),
              m_data, m_wr, m_err, m_lat, m_nrd, m_nwr);
    end

    viol = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) viol++;
    check("final.mem_image", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // For a store, the bytes the model just committed are the store data the DUT must see;
  // unused upper bytes are filled from the reference image so the value is fully defined.
  function automatic logic [31:0] m_wr_src(input logic ld, input logic st, input logic [2:0] f3,
                                           input logic [31:0] a);
    if (st && !ld) return {rb(a, 3), rb(a, 2), rb(a, 1), rb(a, 0)};
    return 32'hA5A5A5A5;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control stage sitting directly upstream of the byte-addressed data memory in the pipelined RISC-V core. It accepts one memory request from EX/MEM and drives the memory's addr, wr_data, mem_read and mem_write. It implements SB/SH as a two-cycle read-modify-write, because the memory only writes whole 4-byte words at addr. It sign- or zero-extends LB/LH/LBU/LHU/LW results and returns a registered response toward MEM/WB. req_ready low stalls the pipeline.

Parameters:
RD_W, 5, width of the destination-register tag passed through to the response.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_load  input  1  request is a load
req_store  input  1  request is a store
req_funct3  input  3  RISC-V funct3 (width/sign of access)
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
req_rd  input  RD_W  destination register tag
mem_addr  output  32  to data memory addr
mem_wr_data  output  32  to data memory wr_data
mem_read  output  1  to data memory mem_read
mem_write  output  1  to data memory mem_write
mem_rd_data  input  32  from data memory rd_data (combinational, bytes addr+3..addr)
resp_valid  output  1  one-cycle response pulse
resp_data  output  32  extended load data; 0 for stores and errors
resp_rd  output  RD_W  captured req_rd
resp_err  output  1  request was illegal

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State goes to IDLE; all captured registers are cleared.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wr_data=0.
  - req_ready=1 once rst deasserts.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
- req_ready = (state==IDLE). A request is accepted at a rising edge when req_valid && req_ready.
- On accept, the block captures addr, wdata, funct3 and rd.
- Next state from IDLE:
  - req_load only, funct3 in {0,1,2,4,5} -> LOAD.
  - req_store only, funct3==2 -> STORE.
  - req_store only, funct3 in {0,1} -> RMW_RD.
  - Any other funct3, both req_load and req_store high, or neither high -> ERR.
- Memory outputs are combinational from state:
  - mem_addr = captured addr in every non-IDLE state.
  - mem_read = 1 in LOAD and RMW_RD only.
  - mem_write = 1 in STORE and RMW_WR only.
  - mem_wr_data = 0 unless mem_write is 1.
- LOAD (1 cycle):
  - resp_data <= extend(mem_rd_data).
  - LB/LH take bits [7:0]/[15:0] and sign-extend.
  - LBU/LHU take the same bits and zero-extend.
  - LW takes all 32 bits.
  - Transition -> IDLE.
- STORE (1 cycle): mem_wr_data = captured wdata; transition -> IDLE.
- RMW_RD (1 cycle):
  - merge <= {mem_rd_data[31:8], wdata[7:0]} for SB.
  - merge <= {mem_rd_data[31:16], wdata[15:0]} for SH.
  - Transition -> RMW_WR.
- RMW_WR (1 cycle): mem_wr_data = merge; transition -> IDLE.
- ERR (1 cycle): no memory access; transition -> IDLE.
- Response: on the edge leaving LOAD, STORE, RMW_WR or ERR, the block registers:
  - resp_valid=1 for exactly one cycle.
  - resp_rd = captured tag.
  - resp_err = 1 only from ERR.
  - resp_data = 0 for store and ERR.
- Latency, counted in edges after the accept edge: 1 for loads, SW and errors; 2 for SB/SH.
- Throughput: at most one request per 2 cycles. The next accept can coincide with the edge that raises resp_valid.
- Addresses need no alignment: the memory handles unaligned words. An RMW rewrites bytes addr+1..addr+3 (addr+2..addr+3 for SH) with their just-read values.
- req_* inputs are ignored while req_ready=0.
- Reset mid-operation aborts the request:
  - No write is issued after reset asserts; mem_write drops asynchronously.
  - No response is produced for the aborted request.

Test Plan:
- Reset: hold rst, then release → req_ready=1, resp_valid=0, mem_read=0, mem_write=0, all outputs 0.
- Preload word 0x8899AABB at 0x10 (byte 0x10=BB). Then:
  - LB 0x13 → resp_data=0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH 0x10 → 0xFFFFAABB.
  - LW 0x10 → 0x8899AABB.
  - Each with resp_valid one edge after accept.
- Same preload, SB addr 0x11, wdata 0x123456CC, rd=7:
  - mem_read for one cycle, then mem_write with mem_wr_data=0x??8899CC.
  - The upper bytes are whatever was read at 0x14, written back unchanged.
  - LW 0x10 afterwards → 0x8899CCBB.
  - resp_valid 2 edges after accept, resp_rd=7.
- SW 0x20 wdata 0xDEADBEEF, then LH 0x22 → 0xFFFFDEAD.
- Illegal requests:
  - Load with funct3=3, store with funct3=5, and req_load and req_store both high → each gives resp_err=1, resp_data=0.
  - mem_read=0 and mem_write=0 throughout.
- Assert rst while in RMW_RD of an SH → no write occurs, no resp_valid, state IDLE, req_ready=1 after release.
